// File: rtl/opcode_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// opcode_sequencer_pkg
// Shared definitions for the CPU front end: sequencer state encoding,
// micro-address width, the NOP micro-address and the default CB-prefix
// constants used when folding prefixed opcodes into the micro-address space.
// No ports (package).
// ----------------------------------------------------------------------------
package opcode_sequencer_pkg;

    localparam int         UADDR_W       = 9;
    localparam logic [8:0] NOP_ADDR      = 9'h000;
    localparam logic [7:0] CB_PREFIX_DEF = 8'hCB;
    localparam logic [8:0] CB_BASE_DEF   = 9'h100;
    localparam logic [8:0] IRQ_ENTRY_DEF = 9'h1F0;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_PREFIX = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALTED = 2'd3
    } seq_state_e;

endpackage

// File: rtl/opcode_sequencer_seq_step_counter.sv
// ----------------------------------------------------------------------------
// seq_step_counter
// Watchdog step counter for the opcode sequencer. Counts micro-steps of the
// current instruction, saturating at 8'hFF, and flags when the count has
// reached the last permitted step (MAX_STEPS-1).
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clear       - restart the count at zero (takes priority over incr)
//   incr        - advance the count by one (saturating)
//   terminal    - count equals MAX_STEPS-1
// ----------------------------------------------------------------------------
module seq_step_counter #(
    parameter int MAX_STEPS = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic incr,
    output logic terminal
);

    localparam logic [7:0] STEP_LAST = 8'(MAX_STEPS - 1);

    logic [7:0] step_q;
    logic [7:0] step_d;

    always_comb begin
        step_d = step_q;
        if (clear) begin
            step_d = 8'h00;
        end else if (incr && (step_q != 8'hFF)) begin
            step_d = step_q + 8'h01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= 8'h00;
        end else begin
            step_q <= step_d;
        end
    end

    assign terminal = (step_q == STEP_LAST);

endmodule

// File: rtl/opcode_sequencer.sv
// ----------------------------------------------------------------------------
// opcode_sequencer
// Front end of the microcoded CPU core. Fetches opcode bytes, folds the CB
// prefix into a 9-bit micro-address, walks multi-cycle instructions using the
// continuation address / end flag from the microcode control word, handles
// HALT and a runaway-sequence watchdog.
// Optional interrupt dispatch is enabled by defining OPCODE_SEQ_IRQ_EN.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   mem_data      - fetched byte
//   mem_valid     - mem_data valid (only looked at while mem_req=1)
//   mem_req       - opcode fetch request (combinational)
//   stall         - freeze the sequencer
//   seq_next      - continuation micro-address from the control word
//   seq_end       - current micro-op ends the instruction
//   seq_halt      - current micro-op executes HALT
//   wake          - releases HALT
//   opcode        - micro-address to the microcode ROM (NOP when not valid)
//   opcode_valid  - opcode is an executing micro-op
//   seq_error     - one-cycle pulse on watchdog expiry
//   irq_req       - (OPCODE_SEQ_IRQ_EN) interrupt dispatch request
//   irq_ack       - (OPCODE_SEQ_IRQ_EN) one-cycle acknowledge pulse
// ----------------------------------------------------------------------------
module opcode_sequencer
    import opcode_sequencer_pkg::*;
#(
    parameter logic [7:0] CB_PREFIX = CB_PREFIX_DEF,
    parameter logic [8:0] CB_BASE   = CB_BASE_DEF,
    parameter int         MAX_STEPS = 15
`ifdef OPCODE_SEQ_IRQ_EN
    ,
    parameter logic [8:0] IRQ_ENTRY = IRQ_ENTRY_DEF
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         mem_data,
    input  logic               mem_valid,
    output logic               mem_req,
    input  logic               stall,
    input  logic [UADDR_W-1:0] seq_next,
    input  logic               seq_end,
    input  logic               seq_halt,
    input  logic               wake,
    output logic [UADDR_W-1:0] opcode,
    output logic               opcode_valid,
    output logic               seq_error
`ifdef OPCODE_SEQ_IRQ_EN
    ,
    input  logic               irq_req,
    output logic               irq_ack
`endif
);

    seq_state_e         state_q, state_d;
    logic [UADDR_W-1:0] opcode_q, opcode_d;
    logic               opcode_valid_q, opcode_valid_d;
    logic               seq_error_q, seq_error_d;
    logic               step_clear;
    logic               step_incr;
    logic               step_terminal;
`ifdef OPCODE_SEQ_IRQ_EN
    logic               irq_ack_q, irq_ack_d;
    logic               irq_take;
`endif

    seq_step_counter #(
        .MAX_STEPS (MAX_STEPS)
    ) u_step (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (step_clear),
        .incr     (step_incr),
        .terminal (step_terminal)
    );

`ifdef OPCODE_SEQ_IRQ_EN
    // An interrupt in FETCH pre-empts the bus fetch entirely.
    assign irq_take = irq_req && (state_q == ST_FETCH);
`endif

    // Gated by rst_n so the bus sees no request while the core is held in reset.
    always_comb begin
        mem_req = rst_n && !stall &&
                  ((state_q == ST_FETCH) || (state_q == ST_PREFIX));
`ifdef OPCODE_SEQ_IRQ_EN
        if (irq_take) begin
            mem_req = 1'b0;
        end
`endif
    end

    // Next-state logic. Pulse outputs default low every cycle, including
    // stalled ones, so a stall never stretches a one-cycle pulse.
    always_comb begin
        state_d        = state_q;
        opcode_d       = opcode_q;
        opcode_valid_d = opcode_valid_q;
        seq_error_d    = 1'b0;
        step_clear     = 1'b0;
        step_incr      = 1'b0;
`ifdef OPCODE_SEQ_IRQ_EN
        irq_ack_d      = 1'b0;
`endif
        if (!stall) begin
            case (state_q)
                ST_FETCH: begin
`ifdef OPCODE_SEQ_IRQ_EN
                    if (irq_req) begin
                        opcode_d       = IRQ_ENTRY;
                        opcode_valid_d = 1'b1;
                        irq_ack_d      = 1'b1;
                        step_clear     = 1'b1;
                        state_d        = ST_EXEC;
                    end else
`endif
                    if (mem_valid) begin
                        if (mem_data == CB_PREFIX) begin
                            state_d = ST_PREFIX;
                        end else begin
                            opcode_d       = {1'b0, mem_data};
                            opcode_valid_d = 1'b1;
                            step_clear     = 1'b1;
                            state_d        = ST_EXEC;
                        end
                    end
                end
                ST_PREFIX: begin
                    // A second CB byte is an ordinary CB-table entry.
                    if (mem_valid) begin
                        opcode_d       = CB_BASE | {1'b0, mem_data};
                        opcode_valid_d = 1'b1;
                        step_clear     = 1'b1;
                        state_d        = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (seq_halt) begin
                        opcode_d       = NOP_ADDR;
                        opcode_valid_d = 1'b0;
                        step_clear     = 1'b1;
                        state_d        = ST_HALTED;
                    end else if (seq_end) begin
                        opcode_d       = NOP_ADDR;
                        opcode_valid_d = 1'b0;
                        step_clear     = 1'b1;
                        state_d        = ST_FETCH;
                    end else if (step_terminal) begin
                        opcode_d       = NOP_ADDR;
                        opcode_valid_d = 1'b0;
                        seq_error_d    = 1'b1;
                        step_clear     = 1'b1;
                        state_d        = ST_FETCH;
                    end else begin
                        opcode_d  = seq_next;
                        step_incr = 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (wake) begin
                        state_d = ST_FETCH;
                    end
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_FETCH;
            opcode_q       <= NOP_ADDR;
            opcode_valid_q <= 1'b0;
            seq_error_q    <= 1'b0;
`ifdef OPCODE_SEQ_IRQ_EN
            irq_ack_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            opcode_q       <= opcode_d;
            opcode_valid_q <= opcode_valid_d;
            seq_error_q    <= seq_error_d;
`ifdef OPCODE_SEQ_IRQ_EN
            irq_ack_q      <= irq_ack_d;
`endif
        end
    end

    assign opcode       = opcode_q;
    assign opcode_valid = opcode_valid_q;
    assign seq_error    = seq_error_q;
`ifdef OPCODE_SEQ_IRQ_EN
    assign irq_ack      = irq_ack_q;
`endif

endmodule

// File: tb/tb_opcode_sequencer.sv
// ----------------------------------------------------------------------------
// tb_opcode_sequencer
// Directed, self-checking bench for opcode_sequencer (default build,
// MAX_STEPS=15). Inputs change 1 time unit after the rising edge, outputs are
// sampled at that same point, away from the active edge.
// ----------------------------------------------------------------------------
module tb_opcode_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] mem_data;
    logic       mem_valid;
    logic       mem_req;
    logic       stall;
    logic [8:0] seq_next;
    logic       seq_end;
    logic       seq_halt;
    logic       wake;
    logic [8:0] opcode;
    logic       opcode_valid;
    logic       seq_error;
`ifdef OPCODE_SEQ_IRQ_EN
    logic       irq_req;
    logic       irq_ack;
`endif

    int errors = 0;
    int checks = 0;

    opcode_sequencer #(
        .MAX_STEPS (15)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_data     (mem_data),
        .mem_valid    (mem_valid),
        .mem_req      (mem_req),
        .stall        (stall),
        .seq_next     (seq_next),
        .seq_end      (seq_end),
        .seq_halt     (seq_halt),
        .wake         (wake),
        .opcode       (opcode),
        .opcode_valid (opcode_valid),
        .seq_error    (seq_error)
`ifdef OPCODE_SEQ_IRQ_EN
        ,
        .irq_req      (irq_req),
        .irq_ack      (irq_ack)
`endif
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compares one observed value against its expected value and counts it.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advances one clock and settles just past the rising edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        mem_data  = 8'h00;
        mem_valid = 1'b0;
        stall     = 1'b0;
        seq_next  = 9'h000;
        seq_end   = 1'b0;
        seq_halt  = 1'b0;
        wake      = 1'b0;
`ifdef OPCODE_SEQ_IRQ_EN
        irq_req   = 1'b0;
`endif
    endtask

    // Presents one byte for a single cycle.
    task automatic fetchByte(input logic [7:0] b);
        mem_data  = b;
        mem_valid = 1'b1;
        applyStimulus();
        mem_valid = 1'b0;
    endtask

    // Ends the current instruction with seq_end for one cycle.
    task automatic endInstr();
        seq_end = 1'b1;
        applyStimulus();
        seq_end = 1'b0;
    endtask

    initial begin
        idleInputs();
        rst_n = 1'b0;

        // Held in reset for two edges.
        applyStimulus();
        applyStimulus();
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_opcode", opcode, 9'h000);
        checkOutput("rst_valid", opcode_valid, 0);
        checkOutput("rst_err", seq_error, 0);

        rst_n = 1'b1;
        #1;
        checkOutput("rel_mem_req", mem_req, 1);

        // Plain one-step instruction 3E.
        fetchByte(8'h3E);
        checkOutput("t1_opcode", opcode, 9'h03E);
        checkOutput("t1_valid", opcode_valid, 1);
        checkOutput("t1_mem_req_exec", mem_req, 0);
        endInstr();
        checkOutput("t1_end_valid", opcode_valid, 0);
        checkOutput("t1_end_opcode", opcode, 9'h000);
        checkOutput("t1_end_mem_req", mem_req, 1);

        // CB prefix then 37.
        fetchByte(8'hCB);
        checkOutput("t2_prefix_valid", opcode_valid, 0);
        checkOutput("t2_prefix_mem_req", mem_req, 1);
        fetchByte(8'h37);
        checkOutput("t2_opcode", opcode, 9'h137);
        checkOutput("t2_valid", opcode_valid, 1);
        endInstr();

        // CB after the prefix is a table entry, not another prefix.
        fetchByte(8'hCB);
        fetchByte(8'hCB);
        checkOutput("t2b_opcode", opcode, 9'h1CB);
        checkOutput("t2b_valid", opcode_valid, 1);
        endInstr();

        // Multi-step walk 03E -> 150 -> 151 -> end.
        fetchByte(8'h3E);
        checkOutput("t3_step0", opcode, 9'h03E);
        seq_next = 9'h150;
        applyStimulus();
        checkOutput("t3_step1", opcode, 9'h150);
        seq_next = 9'h151;
        applyStimulus();
        checkOutput("t3_step2", opcode, 9'h151);
        checkOutput("t3_step2_valid", opcode_valid, 1);
        endInstr();
        checkOutput("t3_end_valid", opcode_valid, 0);
        checkOutput("t3_end_opcode", opcode, 9'h000);

        // Halt and end together: halt wins.
        fetchByte(8'h76);
        seq_halt = 1'b1;
        seq_end  = 1'b1;
        applyStimulus();
        seq_halt = 1'b0;
        seq_end  = 1'b0;
        checkOutput("t4_halt_mem_req", mem_req, 0);
        checkOutput("t4_halt_valid", opcode_valid, 0);
        checkOutput("t4_halt_opcode", opcode, 9'h000);
        for (int i = 0; i < 4; i++) applyStimulus();
        checkOutput("t4_still_halted", mem_req, 0);
        // Wake under stall is ignored.
        wake  = 1'b1;
        stall = 1'b1;
        applyStimulus();
        wake  = 1'b0;
        stall = 1'b0;
        #1;
        checkOutput("t4_stall_beats_wake", mem_req, 0);
        wake = 1'b1;
        applyStimulus();
        wake = 1'b0;
        checkOutput("t4_woken", mem_req, 1);

        // Watchdog: 15 EXEC cycles without end.
        fetchByte(8'h10);
        seq_next = 9'h0AA;
        for (int i = 0; i < 14; i++) applyStimulus();
        checkOutput("t5_pre_err", seq_error, 0);
        checkOutput("t5_pre_opcode", opcode, 9'h0AA);
        checkOutput("t5_pre_valid", opcode_valid, 1);
        applyStimulus();
        checkOutput("t5_err", seq_error, 1);
        checkOutput("t5_err_valid", opcode_valid, 0);
        checkOutput("t5_err_opcode", opcode, 9'h000);
        checkOutput("t5_err_mem_req", mem_req, 1);
        applyStimulus();
        checkOutput("t5_err_pulse", seq_error, 0);

        // Watchdog with a stall in the middle: the step count must freeze.
        fetchByte(8'h11);
        for (int i = 0; i < 10; i++) applyStimulus();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus();
        checkOutput("t5s_stall_valid", opcode_valid, 1);
        stall = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus();
        checkOutput("t5s_no_err_yet", seq_error, 0);
        checkOutput("t5s_still_exec", opcode_valid, 1);
        applyStimulus();
        checkOutput("t5s_err", seq_error, 1);

        // Stall in FETCH drops mem_valid.
        stall = 1'b1;
        #1;
        checkOutput("t6_stall_mem_req", mem_req, 0);
        fetchByte(8'h3E);
        checkOutput("t6_stall_ignored", opcode_valid, 0);
        stall = 1'b0;
        applyStimulus();
        checkOutput("t6_after_stall", opcode_valid, 0);

        // Stall mid-EXEC freezes opcode, then async reset mid-instruction.
        fetchByte(8'h3E);
        seq_next = 9'h150;
        applyStimulus();
        stall    = 1'b1;
        seq_next = 9'h151;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("t7_frozen_opcode", opcode, 9'h150);
        end
        checkOutput("t7_frozen_valid", opcode_valid, 1);
        stall = 1'b0;
        applyStimulus();
        checkOutput("t7_resume", opcode, 9'h151);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t7_rst_opcode", opcode, 9'h000);
        checkOutput("t7_rst_valid", opcode_valid, 0);
        checkOutput("t7_rst_mem_req", mem_req, 0);
        checkOutput("t7_rst_err", seq_error, 0);
        applyStimulus();
        idleInputs();
        rst_n = 1'b1;
        #1;
        checkOutput("t7_rel_mem_req", mem_req, 1);
        fetchByte(8'h42);
        checkOutput("t7_post_opcode", opcode, 9'h042);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/opcode_sequencer.md
Name: opcode_sequencer

Overview:
- Front end of the microcoded CPU core. Fetches opcode bytes from the bus and folds the 0xCB prefix into a 9-bit micro-address.
- Walks multi-cycle instructions using the continuation address and end flag that the microcode ROM returns in its 64-bit control word.
- Drives the 9-bit opcode input of the microcode ROM directly. Also handles HALT and a runaway-sequence watchdog.

Parameters:
- CB_PREFIX, 8'hCB, fetched byte value treated as the prefix.
- CB_BASE, 9'h100, OR-mask applied to the byte fetched after the prefix.
- MAX_STEPS, 15, micro-steps allowed per instruction before the watchdog fires; range 1..255.
- IRQ_ENTRY, 9'h1F0, micro-address injected for interrupt dispatch (optional feature only).

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous, active-low reset
- mem_data  input  8  fetched byte
- mem_valid  input  1  mem_data valid this cycle; sampled only while mem_req=1
- mem_req  output  1  opcode fetch request
- stall  input  1  freeze the sequencer (bus/DMA wait)
- seq_next  input  9  continuation micro-address from the control word
- seq_end  input  1  current micro-op is the last of the instruction
- seq_halt  input  1  current micro-op executes HALT
- wake  input  1  any enabled interrupt flag set; releases HALT
- opcode  output  9  micro-address to the microcode ROM
- opcode_valid  output  1  opcode is an executing micro-op
- seq_error  output  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset:
  - Asynchronous on rst_n low: state=FETCH, opcode=9'h000, opcode_valid=0, step=0, seq_error=0.
  - mem_req is combinational and low while rst_n=0; it goes high in the first cycle after release.
- States: FETCH, PREFIX, EXEC, HALTED. All outputs are registered except mem_req = (state is FETCH or PREFIX) and !stall.
- stall=1 freezes all state and registers. mem_valid is ignored while stalled.
- FETCH, on mem_valid:
  - byte == CB_PREFIX: go to PREFIX.
  - otherwise: opcode <= {1'b0, byte}, opcode_valid <= 1, step <= 0, go to EXEC.
  - Latency: mem_valid at cycle N gives opcode valid at N+1.
- PREFIX, on mem_valid: opcode <= CB_BASE | byte, opcode_valid <= 1, go to EXEC. A CB byte here is a normal CB-table entry, not a second prefix.
- EXEC, each unstalled cycle, in priority order:
  1. seq_halt: go to HALTED, opcode_valid <= 0, opcode <= 9'h000.
  2. seq_end: go to FETCH, opcode_valid <= 0, opcode <= 9'h000.
  3. step == MAX_STEPS-1: pulse seq_error, go to FETCH, opcode_valid <= 0.
  4. otherwise: opcode <= seq_next, step <= step+1.
- seq_halt and seq_end together: HALTED wins.
- step is 8 bits and saturates; it never wraps.
- HALTED: mem_req=0. On wake, go to FETCH the next cycle. wake and stall together: stall wins.
- opcode holds 9'h000 (NOP) whenever opcode_valid=0, so the ROM output stays benign.
- Reset mid-instruction aborts immediately; no partial state survives.

Optional Feature:
- Macro: OPCODE_SEQ_IRQ_EN.
- Enabled:
  - Adds ports irq_req (input, 1) and irq_ack (output, 1, registered pulse).
  - In FETCH with irq_req=1 and !stall, the bus fetch is suppressed: mem_req=0, opcode <= IRQ_ENTRY, opcode_valid <= 1, irq_ack pulses, go to EXEC.
  - irq_req takes priority over a same-cycle mem_valid; that byte is dropped.
- Disabled: the ports are absent and FETCH behaves as above.

Decomposition:
- Shared cpu package holds:
  - state encoding (2 bits: FETCH=0, PREFIX=1, EXEC=2, HALTED=3);
  - micro-address width constant (9);
  - the NOP address 9'h000;
  - CB_PREFIX and CB_BASE defaults.
- The watchdog step counter is a natural sub-module, seq_step_counter: clear, increment, saturate and terminal-compare against MAX_STEPS.

Test Plan:
- Reset released, mem_valid with 8'h3E, then seq_end the next cycle -> opcode=9'h03E valid for 1 cycle, then FETCH with mem_req=1.
- Bytes 8'hCB then 8'h37 -> PREFIX entered; opcode=9'h137 one cycle after the second mem_valid.
- In EXEC, seq_next=9'h150 then 9'h151, then seq_end -> opcode sequence 03E, 150, 151, then opcode_valid=0.
- seq_halt and seq_end asserted together -> HALTED, mem_req=0; wake after 5 cycles -> FETCH one cycle later.
- seq_end never asserted with MAX_STEPS=15 -> seq_error pulses on the 15th EXEC cycle; state returns to FETCH.
- stall held 3 cycles mid-EXEC, then rst_n pulsed low mid-instruction -> opcode/step frozen during stall; on reset all outputs return to their reset values asynchronously.
